// File: rtl/gf_mac_pipe.sv
// gf_mac_pipe: two-stage pipelined GF(2^M) multiply / multiply-accumulate with valid/ready handshake
module gf_mac_pipe #(
  parameter int M = 8,
  parameter logic [M:0] POLY = 9'h11D
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_a,
  input  logic [M-1:0] in_b,
  input  logic         in_mac,
  input  logic         in_clr,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data,
  output logic         out_last,
  output logic [M-1:0] acc_q
);
  localparam logic [2*M-2:0] PW = (2*M-1)'(POLY);
  if (M < 2 || M > 16 || POLY[M] != 1'b1) begin : g_bad
    $error("gf_mac_pipe: M must be 2..16 and POLY[M] must be 1");
  end
  logic           adv;
  logic           s1_valid;
  logic           s1_mac;
  logic           s1_clr;
  logic           s1_last;
  logic [2*M-2:0] s1_p;
  logic [2*M-2:0] prod;
  logic [2*M-2:0] red;
  logic [M-1:0]   res;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  // carry-less product of the incoming operands
  always_comb begin
    prod = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        prod[i+j] = prod[i+j] ^ (in_a[i] & in_b[j]);
  end
  // reduce stage-1 product mod POLY and fold in the accumulator
  always_comb begin
    red = s1_p;
    for (int k = 2*M-2; k >= M; k--)
      if (red[k]) red = red ^ (PW << (k - M));
    res = s1_mac ? ((s1_clr ? '0 : acc_q) ^ red[M-1:0]) : red[M-1:0];
  end
  // stage 1: capture product and sideband when the pipe advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mac   <= 1'b0;
      s1_clr   <= 1'b0;
      s1_last  <= 1'b0;
      s1_p     <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_mac   <= in_mac;
      s1_clr   <= in_clr;
      s1_last  <= in_last;
      s1_p     <= prod;
    end
  end
  // stage 2: output register and accumulator, written only on advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      acc_q     <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      out_data  <= res;
      out_last  <= s1_last;
      if (s1_valid && s1_mac) acc_q <= res;
    end
  end
endmodule

// File: tb/tb_gf_mac_pipe.sv
// tb_gf_mac_pipe: directed and swept checks of gf_mac_pipe with M=8, POLY=0x11D
module tb_gf_mac_pipe;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       in_mac = 1'b0;
  logic       in_clr = 1'b0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_last;
  logic [7:0] acc_q;
  int checks = 0;
  int errors = 0;

  gf_mac_pipe #(.M(8), .POLY(9'h11D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mac(in_mac), .in_clr(in_clr), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .acc_q(acc_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic mac, input logic clr, input logic last);
    in_valid = v; in_a = a; in_b = b; in_mac = mac; in_clr = clr; in_last = last;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      r = r << 1;
      if (r[8]) r = r ^ 9'h11D;
      if (b[i]) r = r ^ {1'b0, a};
    end
    return r[7:0];
  endfunction

  logic [7:0] pa [5] = '{8'h02, 8'h03, 8'hFF, 8'h80, 8'h00};
  logic [7:0] pb [5] = '{8'h80, 8'h03, 8'h01, 8'h80, 8'h5A};
  logic [7:0] pe [5] = '{8'h1D, 8'h05, 8'hFF, 8'h13, 8'h00};
  logic [7:0] q [$];

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_acc", 16'(acc_q), 16'h0);
    chk("rst_out_data", 16'(out_data), 16'h0);
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("prod_valid", 16'(out_valid), 16'h1);
        chk("prod_data", 16'(out_data), 16'(pe[i-2]));
      end
      if (i < 5) drive(1'b1, pa[i], pb[i], 1'b0, 1'b0, 1'b0);
      else drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    chk("prod_acc_untouched", 16'(acc_q), 16'h0);

    @(negedge clk); drive(1'b1, 8'h02, 8'h80, 1'b1, 1'b1, 1'b0);
    @(negedge clk); drive(1'b1, 8'h03, 8'h03, 1'b1, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("mac1_data", 16'(out_data), 16'h1D);
    chk("mac1_acc", 16'(acc_q), 16'h1D);
    @(negedge clk); drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mac2_data", 16'(out_data), 16'h18);
    chk("mac2_acc", 16'(acc_q), 16'h18);
    @(negedge clk);
    chk("mul3_data", 16'(out_data), 16'hFF);
    chk("mul3_acc", 16'(acc_q), 16'h18);

    drive(1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 8'h03, 8'h03, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 16'(out_valid), 16'h0);
    chk("async_rst_acc", 16'(acc_q), 16'h0);
    @(negedge clk); drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_out", 16'(out_valid), 16'h0);
    end

    @(negedge clk); drive(1'b1, 8'h02, 8'h80, 1'b1, 1'b1, 1'b0); out_ready = 1'b1;
    @(negedge clk); drive(1'b1, 8'h03, 8'h03, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_first_data", 16'(out_data), 16'h1D);
    chk("bp_first_acc", 16'(acc_q), 16'h1D);
    out_ready = 1'b0; drive(1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
    #1 chk("bp_in_ready", 16'(in_ready), 16'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 16'(out_valid), 16'h1);
      chk("bp_hold_data", 16'(out_data), 16'h1D);
      chk("bp_hold_acc", 16'(acc_q), 16'h1D);
      chk("bp_hold_ready", 16'(in_ready), 16'h0);
    end
    @(negedge clk); out_ready = 1'b1;
    chk("bp_hold3_data", 16'(out_data), 16'h1D);
    @(negedge clk);
    chk("bp_second_data", 16'(out_data), 16'h18);
    chk("bp_second_acc", 16'(acc_q), 16'h18);
    drive(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("bp_third_data", 16'(out_data), 16'h0B);
    chk("bp_third_acc", 16'(acc_q), 16'h0B);
    @(negedge clk);
    chk("bp_final_data", 16'(out_data), 16'hF4);
    chk("bp_final_acc", 16'(acc_q), 16'hF4);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("bub_valid", 16'(out_valid), 16'((i % 2) == 0));
        if (out_valid) chk("bub_last", 16'(out_last), 16'(i == 6));
      end
      drive(i < 6 && (i % 2) == 0, 8'h03, 8'h03, 1'b0, 1'b0, i == 4);
    end

    begin
      int idx = 0;
      int n = 0;
      while ((idx < 4096 || q.size() > 0) && n < 20000) begin
        @(negedge clk);
        n++;
        out_ready = ($urandom_range(3) != 0);
        if (idx < 4096) drive(1'b1, 8'(idx), 8'(idx[11:8] * 17), 1'b0, 1'b0, 1'b0);
        else drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        if (out_valid && out_ready) begin
          if (q.size() == 0) chk("sweep_spurious", 16'(out_valid), 16'h0);
          else chk("sweep_data", 16'(out_data), 16'(q.pop_front()));
        end
        if (in_valid && in_ready) begin
          q.push_back(gmul(in_a, in_b));
          idx++;
        end
      end
      chk("sweep_complete", 16'(idx), 16'd4096);
      chk("sweep_drained", 16'(q.size()), 16'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
